// File: rtl/barret_2273_pkg.sv
// barret_2273_pkg: shared constants and types for the mod-2273 reducer and its scheduler.
package barret_2273_pkg;
   localparam int Q      = 2273;
   localparam int Q_SQ   = 5166529;
   localparam int DIN_W  = 23;
   localparam int DOUT_W = 12;
   // Barrett constants: BM = floor(2^BK / Q); quotient estimate is off by at most one
   localparam int BK     = 24;
   localparam int BM     = 7381;
   localparam int BM_W   = 13;
   typedef logic [DIN_W-1:0]  operand_t;
   typedef logic [DOUT_W-1:0] residue_t;
   function automatic logic in_range(input operand_t x);
      return x < operand_t'(Q_SQ);
   endfunction
endpackage

// File: rtl/barret_2273_rr_sched_if.sv
// barret_2273_rr_sched_if: requester/result bundle between the requesters and the shared reducer.
interface barret_2273_rr_sched_if
   import barret_2273_pkg::*;
#(parameter int NREQ = 4) ();
   localparam int ID_W = $clog2(NREQ);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DIN_W-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  out_valid;
   logic [DOUT_W-1:0]     out_data;
   logic [ID_W-1:0]       out_id;
   logic                  out_err;
   logic                  out_ready;
   modport master (output req_valid, req_data, out_ready,
                   input  req_ready, out_valid, out_data, out_id, out_err);
   modport slave  (input  req_valid, req_data, out_ready,
                   output req_ready, out_valid, out_data, out_id, out_err);
endinterface

// File: rtl/barret_for_2273.sv
// barret_for_2273: combinational Barrett reduction of a 23-bit operand modulo 2273.
module barret_for_2273
   import barret_2273_pkg::*;
(
   input  logic [DIN_W-1:0]  din_a,
   output logic [DOUT_W-1:0] dout_r
);
   localparam int PW = DIN_W + BM_W;
   localparam logic [DOUT_W:0] LQ = (DOUT_W+1)'(Q);
   logic [PW-1:0]     w_prod;
   logic [DOUT_W-1:0] w_qhat;
   logic [DIN_W-1:0]  w_sub;
   logic [DOUT_W:0]   w_r;
   assign w_prod = PW'(din_a) * PW'(BM);
   assign w_qhat = DOUT_W'(w_prod >> BK);
   assign w_sub  = din_a - DIN_W'(DIN_W'(w_qhat) * DIN_W'(Q));
   // remainder estimate lies in [0, 2Q), so a single correction suffices
   assign w_r    = (DOUT_W+1)'(w_sub);
   assign dout_r = (w_r >= LQ) ? DOUT_W'(w_r - LQ) : DOUT_W'(w_r);
endmodule

// File: rtl/barret_2273_rr_sched.sv
// barret_2273_rr_sched: round-robin sharing of one mod-2273 reducer among NREQ requesters,
// with a single-entry result register.
module barret_2273_rr_sched
   import barret_2273_pkg::*;
#(parameter int NREQ = 4)
(
   input logic clk,
   input logic rst_n,
   barret_2273_rr_sched_if.slave bus
);
   localparam int ID_W = $clog2(NREQ);
   logic [ID_W-1:0] r_ptr, r_id, w_win;
   logic            r_valid, r_err, w_found, w_can, w_accept;
   residue_t        r_data, w_dout;
   operand_t        w_din;
   // scan from the farthest offset down so the nearest valid index after r_ptr wins
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (bus.req_valid[r_ptr + ID_W'(k)]) begin
            w_win   = r_ptr + ID_W'(k);
            w_found = 1'b1;
         end
   end
   assign w_can         = ~r_valid | bus.out_ready;
   assign w_accept      = w_found & w_can;
   assign bus.req_ready = w_accept ? NREQ'(1) << w_win : '0;
   assign w_din         = bus.req_data[w_win*DIN_W +: DIN_W];
   barret_for_2273 u_red (.din_a(w_din), .dout_r(w_dout));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_id    <= '0;
         r_err   <= 1'b0;
         r_ptr   <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_data  <= in_range(w_din) ? w_dout : '0;
         r_id    <= w_win;
         r_err   <= ~in_range(w_din);
         r_ptr   <= w_win + 1'b1;
      end else if (bus.out_ready)
         r_valid <= 1'b0;
   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_id    = r_id;
   assign bus.out_err   = r_err;
endmodule

// File: tb/tb_barret_2273_rr_sched.sv
// tb_barret_2273_rr_sched: directed checks of arbitration, handshake, reset and mod-2273 results.
module tb_barret_2273_rr_sched;
   import barret_2273_pkg::*;
   logic clk, rst_n;
   int   n_tot, n_bad;
   barret_2273_rr_sched_if #(.NREQ(4)) bus ();
   barret_2273_rr_sched #(.NREQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // one accept from requester r, then check the registered result
   task automatic xfer(input int r, input int v, input int exp_d, input logic exp_e);
      bus.req_valid = 4'(1 << r);
      bus.req_data[r*DIN_W +: DIN_W] = DIN_W'(v);
      #1;
      chk("xfer_rdy", 32'(bus.req_ready), 32'(1 << r));
      tick();
      bus.req_valid = '0;
      chk("xfer_vld", 32'(bus.out_valid), 1);
      chk("xfer_id", 32'(bus.out_id), 32'(r));
      chk("xfer_err", 32'(bus.out_err), 32'(exp_e));
      chk("xfer_data", 32'(bus.out_data), 32'(exp_d));
   endtask
   initial begin
      n_tot = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.out_ready = 1'b1;
      #3;
      chk("rst_vld", 32'(bus.out_valid), 0);
      chk("rst_data", 32'(bus.out_data), 0);
      chk("rst_id", 32'(bus.out_id), 0);
      chk("rst_err", 32'(bus.out_err), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("idle_vld", 32'(bus.out_valid), 0);
      xfer(2, 4546, 0, 1'b0);
      xfer(2, 5166528, 2272, 1'b0);
      xfer(1, 5166529, 0, 1'b1);
      xfer(0, 5166528, 2272, 1'b0);
      xfer(3, 15922, 11, 1'b0);
      tick();
      chk("drain_vld", 32'(bus.out_valid), 0);
      // asynchronous reset while a result is held
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b0001;
      bus.req_data[0 +: DIN_W] = 23'd100;
      tick();
      bus.req_valid = '0;
      chk("hold_vld", 32'(bus.out_valid), 1);
      chk("hold_data", 32'(bus.out_data), 100);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_vld", 32'(bus.out_valid), 0);
      chk("arst_data", 32'(bus.out_data), 0);
      chk("arst_id", 32'(bus.out_id), 0);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      chk("post_rst_vld", 32'(bus.out_valid), 0);
      // fairness: all valid, grants rotate 0,1,2,3,0
      for (int i = 0; i < 4; i++) bus.req_data[i*DIN_W +: DIN_W] = DIN_W'(2273 * i + 100 + i);
      bus.req_valid = 4'hF;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("rr_grant", 32'(bus.req_ready), 32'(1 << (c % 4)));
         tick();
         chk("rr_id", 32'(bus.out_id), 32'(c % 4));
         chk("rr_data", 32'(bus.out_data), 32'(100 + c % 4));
      end
      // backpressure: held result stable, nobody granted
      bus.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_rdy", 32'(bus.req_ready), 0);
         tick();
         chk("bp_vld", 32'(bus.out_valid), 1);
         chk("bp_id", 32'(bus.out_id), 0);
         chk("bp_data", 32'(bus.out_data), 100);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_resume", 32'(bus.req_ready), 32'b0010);
      tick();
      chk("bp_res_id", 32'(bus.out_id), 1);
      chk("bp_res_data", 32'(bus.out_data), 101);
      bus.req_valid = '0;
      tick();
      chk("drop_vld", 32'(bus.out_valid), 0);
      bus.req_valid = 4'hF;
      #1;
      chk("ptr_hold", 32'(bus.req_ready), 32'b0100);
      bus.req_data[2*DIN_W +: DIN_W] = 23'd8388607;
      #1;
      chk("rdy_no_data", 32'(bus.req_ready), 32'b0100);
      bus.req_valid = '0;
      tick();
      // boundary operands
      begin
         int bnd[10] = '{0, 1, 2272, 2273, 2274, 4545, 5164256, 5166528, 5166529, 8388607};
         foreach (bnd[j])
            xfer(j % 4, bnd[j], bnd[j] >= Q_SQ ? 0 : bnd[j] % Q, bnd[j] >= Q_SQ);
      end
      // strided and random sweep through every requester
      for (int j = 0; j < 300; j++) xfer(j % 4, j * 17201 + j % 7, (j * 17201 + j % 7) % Q, 1'b0);
      for (int j = 0; j < 2000; j++) begin
         int v;
         v = int'($urandom_range(Q_SQ - 1, 0));
         xfer(j % 4, v, v % Q, 1'b0);
      end
      for (int j = 0; j < 40; j++) xfer(j % 4, int'($urandom_range(8388607, Q_SQ)), 0, 1'b1);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
